// File: rtl/icc_rx_link.sv
// icc_rx_link: receive-side framer for the inter-chip link.
// Locks to the periodic comma word, strips commas, delivers payload words with a
// one-cycle valid strobe, counts comma and code errors, and requests a GT reset
// after a prolonged loss of lock. Single clock domain (rxusrclk).
module icc_rx_link #(
    parameter int unsigned        DWIDTH        = 32,
    parameter logic [DWIDTH-1:0]  COMMA         = DWIDTH'(32'h000000bc),
    parameter int unsigned        COMMA_PERIOD  = 16,
    parameter int unsigned        LOCK_COUNT    = 4,
    parameter int unsigned        LOSS_COUNT    = 2,
    parameter int unsigned        CNT_WIDTH     = 16,
    parameter int unsigned        RESET_TIMEOUT = 65536
) (
    input  logic                  rxusrclk_i,
    input  logic                  sreset_i,
    input  logic [DWIDTH-1:0]     rxdata_i,
    input  logic [DWIDTH/8-1:0]   rxcharisk_i,
    input  logic [DWIDTH/8-1:0]   rxdisperr_i,
    input  logic [DWIDTH/8-1:0]   rxnotintable_i,
    input  logic                  clr_cnt_i,
    output logic [DWIDTH-1:0]     dout_o,
    output logic                  dout_valid_o,
    output logic                  locked_o,
    output logic [CNT_WIDTH-1:0]  comma_err_cnt_o,
    output logic [CNT_WIDTH-1:0]  code_err_cnt_o,
    output logic                  gt_reset_req_o
);

    localparam int unsigned DBYTE  = DWIDTH / 8;
    localparam int unsigned PH_W   = $clog2(COMMA_PERIOD);
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_COUNT + 1);
    localparam int unsigned TO_W   = $clog2(RESET_TIMEOUT);

    localparam logic [GOOD_W-1:0] LOCK_N  = GOOD_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0] LOSS_N  = MISS_W'(LOSS_COUNT);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(RESET_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [GOOD_W-1:0]     good_q, good_d;
    logic [MISS_W-1:0]     miss_q, miss_d;
    logic [TO_W-1:0]       timeout_q, timeout_d;
    logic [DWIDTH-1:0]     dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  locked_q;
    logic [CNT_WIDTH-1:0]  comma_err_q, comma_err_d;
    logic [CNT_WIDTH-1:0]  code_err_q, code_err_d;
    logic                  gt_req_q, gt_req_d;

    logic                  code_err;
    logic                  is_comma;
    logic                  is_payload;
    logic                  at_slot;
    logic                  comma_miss;

    // Classify the incoming word.
    always_comb begin
        code_err   = |(rxdisperr_i | rxnotintable_i);
        is_comma   = (rxcharisk_i == {DBYTE{1'b1}}) && (rxdata_i == COMMA) && !code_err;
        is_payload = (rxcharisk_i == '0) && !code_err;
        at_slot    = (phase_q == '0);
    end

    // Framing FSM, payload capture, timeout and error counters (next-state logic).
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; an unassigned path in combinational logic infers a latch.
        state_d      = state_q;
        phase_d      = phase_q + 1'b1;
        good_d       = good_q;
        miss_d       = miss_q;
        timeout_d    = timeout_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        gt_req_d     = 1'b0;
        comma_miss   = 1'b0;
        comma_err_d  = comma_err_q;
        code_err_d   = code_err_q;

        unique case (state_q)
            ST_HUNT: begin
                if (is_comma) begin
                    state_d = ST_VERIFY;
                    phase_d = PH_W'(1);
                    good_d  = GOOD_W'(1);
                end
            end
            ST_VERIFY: begin
                if (at_slot) begin
                    if (is_comma) begin
                        good_d = good_q + 1'b1;
                        if (good_d == LOCK_N) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        state_d = ST_HUNT;
                        good_d  = '0;
                    end
                end else if (is_comma) begin
                    state_d = ST_HUNT;
                    good_d  = '0;
                end
            end
            ST_LOCKED: begin
                if (at_slot && is_comma) begin
                    miss_d = '0;
                end else if (at_slot || is_comma) begin
                    // Missing slot comma or misplaced comma; alignment is kept.
                    comma_miss = 1'b1;
                    miss_d     = miss_q + 1'b1;
                    if (miss_d == LOSS_N) begin
                        state_d = ST_HUNT;
                        good_d  = '0;
                    end
                end
                if (!at_slot && is_payload) begin
                    dout_d       = rxdata_i;
                    dout_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_HUNT;
                good_d  = '0;
            end
        endcase

        // Prolonged loss of lock: pulse a GT reset request and restart the hunt.
        if (state_q == ST_LOCKED) begin
            timeout_d = '0;
        end else if (timeout_q == TO_LAST) begin
            timeout_d = '0;
            gt_req_d  = 1'b1;
            state_d   = ST_HUNT;
            good_d    = '0;
        end else begin
            timeout_d = timeout_q + 1'b1;
        end

        // Saturating error counters; clear has priority over increment.
        if (clr_cnt_i) begin
            comma_err_d = '0;
        end else if (comma_miss && (comma_err_q != '1)) begin
            comma_err_d = comma_err_q + 1'b1;
        end

        if (clr_cnt_i) begin
            code_err_d = '0;
        end else if (code_err && (code_err_q != '1)) begin
            code_err_d = code_err_q + 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge rxusrclk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (sreset_i) begin
            state_q      <= ST_HUNT;
            phase_q      <= '0;
            good_q       <= '0;
            miss_q       <= '0;
            timeout_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            comma_err_q  <= '0;
            code_err_q   <= '0;
            gt_req_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            good_q       <= good_d;
            miss_q       <= miss_d;
            timeout_q    <= timeout_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            locked_q     <= (state_d == ST_LOCKED);
            comma_err_q  <= comma_err_d;
            code_err_q   <= code_err_d;
            gt_req_q     <= gt_req_d;
        end
    end

    assign dout_o          = dout_q;
    assign dout_valid_o    = dout_valid_q;
    assign locked_o        = locked_q;
    assign comma_err_cnt_o = comma_err_q;
    assign code_err_cnt_o  = code_err_q;
    assign gt_reset_req_o  = gt_req_q;

endmodule

// File: tb/tb_icc_rx_link.sv
// tb_icc_rx_link: directed scenarios plus a randomized stream, every cycle compared
// against a behavioural model that tracks comma alignment as an anchor cycle number.
module tb_icc_rx_link;

    localparam int          P      = 16;
    localparam int          LOCK_N = 4;
    localparam int          LOSS_N = 2;
    localparam int          CW     = 8;
    localparam int          TMO    = 300;
    localparam logic [31:0] COMMA_W = 32'h000000bc;
    localparam int          CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          sreset;
    logic [31:0]   rxdata;
    logic [3:0]    rxcharisk, rxdisperr, rxnotintable;
    logic          clr_cnt;
    logic [31:0]   dout;
    logic          dout_valid, locked, gt_reset_req;
    logic [CW-1:0] comma_err_cnt, code_err_cnt;

    always #5 clk = ~clk;

    icc_rx_link #(
        .DWIDTH(32), .COMMA_PERIOD(P), .LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N),
        .CNT_WIDTH(CW), .RESET_TIMEOUT(TMO)
    ) dut (
        .rxusrclk_i(clk), .sreset_i(sreset), .rxdata_i(rxdata), .rxcharisk_i(rxcharisk),
        .rxdisperr_i(rxdisperr), .rxnotintable_i(rxnotintable), .clr_cnt_i(clr_cnt),
        .dout_o(dout), .dout_valid_o(dout_valid), .locked_o(locked),
        .comma_err_cnt_o(comma_err_cnt), .code_err_cnt_o(code_err_cnt),
        .gt_reset_req_o(gt_reset_req)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0=hunting, 1=verifying, 2=locked; comma slots are the
    // cycles whose distance from the anchor comma is a multiple of P.
    int          m_mode, m_cyc, m_anchor, m_good, m_miss, m_idle, m_cerr, m_code;
    logic [31:0] m_dout;
    bit          m_valid, m_gt;

    task automatic model_step(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de,
                              input logic [3:0] ni, input bit clr, input bit srst);
        bit cerr, comma, slot, miss_ev;
        int prev;
        if (srst) begin
            m_mode = 0; m_cyc = 0; m_anchor = 0; m_good = 0; m_miss = 0; m_idle = 0;
            m_cerr = 0; m_code = 0; m_dout = '0; m_valid = 0; m_gt = 0;
            return;
        end
        cerr    = ((de | ni) != 4'h0);
        comma   = (k == 4'hF) && (d == COMMA_W) && !cerr;
        slot    = ((m_cyc - m_anchor) % P) == 0;
        prev    = m_mode;
        m_valid = 0;
        m_gt    = 0;
        miss_ev = 0;
        if (prev == 0) begin
            if (comma) begin m_mode = 1; m_anchor = m_cyc; m_good = 1; end
        end else if (prev == 1) begin
            if (slot && comma) begin
                m_good++;
                if (m_good == LOCK_N) begin m_mode = 2; m_miss = 0; end
            end else if (slot || comma) begin
                m_mode = 0; m_good = 0;
            end
        end else begin
            if (!slot && k == 4'h0 && !cerr) begin m_dout = d; m_valid = 1; end
            if (slot != comma) begin
                miss_ev = 1;
                m_miss++;
                if (m_miss >= LOSS_N) begin m_mode = 0; m_good = 0; end
            end else if (slot) begin
                m_miss = 0;
            end
        end
        if (prev != 2) begin
            if (m_idle == TMO - 1) begin
                m_gt = 1; m_idle = 0; m_mode = 0; m_good = 0;
            end else begin
                m_idle++;
            end
        end else begin
            m_idle = 0;
        end
        if (clr) m_cerr = 0;
        else if (miss_ev && m_cerr < CMAX) m_cerr++;
        if (clr) m_code = 0;
        else if (cerr && m_code < CMAX) m_code++;
        m_cyc++;
    endtask

    int n_strobe = 0;
    int n_gt     = 0;
    int tcount   = 0;
    int gt_t[2];
    int dcnt     = 1;

    // One clock cycle: drive on the falling edge, compare just after the rising edge.
    task automatic cyc(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de,
                       input logic [3:0] ni, input bit clr, input bit srst);
        @(negedge clk);
        rxdata = d; rxcharisk = k; rxdisperr = de; rxnotintable = ni;
        clr_cnt = clr; sreset = srst;
        model_step(d, k, de, ni, clr, srst);
        @(posedge clk);
        #1;
        check("dout", dout, m_dout);
        check("dout_valid", dout_valid, m_valid);
        check("locked", locked, (m_mode == 2));
        check("comma_err_cnt", comma_err_cnt, m_cerr);
        check("code_err_cnt", code_err_cnt, m_code);
        check("gt_reset_req", gt_reset_req, m_gt);
        tcount++;
        if (dout_valid) n_strobe++;
        if (gt_reset_req) begin
            if (n_gt < 2) gt_t[n_gt] = tcount;
            n_gt++;
        end
    endtask

    task automatic data_w();
        cyc(dcnt, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        dcnt++;
    endtask

    task automatic comma_w();
        cyc(COMMA_W, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic data15();
        for (int j = 0; j < 15; j++) data_w();
    endtask

    task automatic period(input int n);
        for (int j = 0; j < n; j++) begin
            comma_w();
            data15();
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  k, de, ni;
        bit          clr, srst;
        int          r, gph;

        rxdata = '0; rxcharisk = '0; rxdisperr = '0; rxnotintable = '0;
        clr_cnt = 1'b0; sreset = 1'b1;
        cyc(32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        cyc(32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        check("rst_locked", locked, 1'b0);
        check("rst_dout", dout, 32'h0);

        // Clean stream: lock one cycle after the fourth comma, then 15 strobes per period.
        for (int i = 0; i < 4; i++) begin
            comma_w();
            check("t1_lock_timing", locked, (i == 3));
            data15();
        end
        n_strobe = 0;
        period(4);
        check("t1_strobes", n_strobe, 60);
        check("t1_no_comma_err", comma_err_cnt, 0);

        // One slot comma replaced by payload-looking data: counted, not emitted, lock kept.
        cyc(32'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        check("t2_locked", locked, 1'b1);
        check("t2_cerr", comma_err_cnt, 1);
        check("t2_no_strobe", dout_valid, 1'b0);
        data15();
        comma_w();
        data15();
        cyc(32'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        check("t2_miss_cleared", locked, 1'b1);
        data15();

        // Two consecutive missing slot commas drop lock; four fresh commas restore it.
        comma_w();
        cyc(dcnt, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        dcnt++;
        check("t3_clr", comma_err_cnt, 0);
        for (int j = 0; j < 14; j++) data_w();
        data_w();
        data15();
        data_w();
        check("t3_unlocked", locked, 1'b0);
        check("t3_cerr", comma_err_cnt, 2);
        n_strobe = 0;
        data15();
        check("t3_no_strobes", n_strobe, 0);
        for (int i = 0; i < 4; i++) begin
            comma_w();
            check("t3_relock", locked, (i == 3));
            data15();
        end

        // Reset while locked clears everything on the next cycle.
        cyc(32'h5555, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        check("t6_rst_locked", locked, 1'b0);
        check("t6_rst_dout", dout, 32'h0);
        check("t6_rst_cerr", comma_err_cnt, 0);

        // Misplaced comma during verification restarts the hunt.
        comma_w();
        data15();
        comma_w();
        for (int j = 0; j < 6; j++) data_w();
        comma_w();
        for (int j = 0; j < 8; j++) data_w();
        for (int i = 0; i < 4; i++) begin
            comma_w();
            check("t4_relock", locked, (i == 3));
            data15();
        end

        // Code errors: no strobe, saturation, clear beats same-cycle increment.
        comma_w();
        cyc(32'hABCD, 4'h0, 4'b0010, 4'h0, 1'b0, 1'b0);
        check("t5_no_strobe", dout_valid, 1'b0);
        check("t5_code1", code_err_cnt, 1);
        for (int j = 0; j < 14; j++) data_w();
        for (int i = 0; i < 20; i++) begin
            comma_w();
            for (int j = 0; j < 15; j++) begin
                cyc(dcnt, 4'h0, 4'h0, 4'b0100, 1'b0, 1'b0);
                dcnt++;
            end
        end
        check("t5_saturate", code_err_cnt, CMAX);
        cyc(32'h77, 4'h0, 4'b0001, 4'h0, 1'b1, 1'b0);
        check("t5_clr_wins", code_err_cnt, 0);

        // No commas: one reset-request pulse per timeout interval.
        cyc(32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        n_gt = 0;
        for (int j = 0; j < 700; j++) data_w();
        check("t6_gt_pulses", n_gt, 2);
        check("t6_gt_interval", gt_t[1] - gt_t[0], TMO);

        // Randomized stream around a nominal comma grid.
        gph = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            d = $urandom; k = 4'h0; de = 4'h0; ni = 4'h0;
            if (gph == 0) begin
                if (r >= 30) begin d = COMMA_W; k = 4'hF; end
            end else if (r < 20) begin
                d = COMMA_W; k = 4'hF;
            end else if (r < 40) begin
                k = 4'(1 << $urandom_range(0, 3));
            end
            if ($urandom_range(0, 99) < 3) de = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 99) < 2) ni = 4'($urandom_range(1, 15));
            clr  = ($urandom_range(0, 199) == 0);
            srst = ($urandom_range(0, 999) < 2);
            cyc(d, k, de, ni, clr, srst);
            gph = (gph + 1) % P;
            if ($urandom_range(0, 499) == 0) gph = (gph + 1) % P;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
